mmio_seg_display: RTL and testbench
===================================

MMIO_SEG_DISPLAY -- requirements
Module: mmio_seg_display

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0400, byte address of the VALUE register; the CTRL register is at BASE_ADDR+4.
REQ-002 Parameter REFRESH_DIV, default 50000, clock cycles each digit is lit; legal range 2..2^20.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 mem_write  input  1  CPU store strobe, one cycle per store.
REQ-006 data_adr  input  32  CPU data address.
REQ-007 write_data  input  32  CPU store data.
REQ-008 rd_data  output  32  read-back of the addressed register, combinational from data_adr.
REQ-009 hit  output  1  high when data_adr equals BASE_ADDR or BASE_ADDR+4.
REQ-010 segments  output  7  active-low segment drive, bit order {g,f,e,d,c,b,a}.
REQ-011 digit_n  output  4  active-low digit enables; bit 0 is the rightmost digit.

Function
REQ-012 A store with mem_write=1 and data_adr=BASE_ADDR SHALL load write_data[15:0] into VALUE on that edge; bits 31:16 are ignored.
REQ-013 A store to BASE_ADDR+4 SHALL load write_data[4:0] into CTRL: bits [3:0] are per-digit enables, bit 4 is BLINK.
REQ-014 A store to any other address SHALL change no state; hit=0 and rd_data=0 for unmapped addresses.
REQ-015 rd_data SHALL be {16'b0,VALUE} at BASE_ADDR and {27'b0,CTRL} at BASE_ADDR+4.
REQ-016 The scan FSM SHALL have two states: SHOW (one digit lit) and GAP (all digits off for exactly 1 cycle, anti-ghosting).
REQ-017 In SHOW, a refresh counter SHALL count 0..REFRESH_DIV-1; at REFRESH_DIV-1 the FSM goes to GAP and the counter clears.
REQ-018 From GAP the FSM SHALL return to SHOW with the digit index incremented modulo 4 (3 wraps to 0).
REQ-019 In SHOW, digit_n[idx]=0 only if CTRL[idx]=1; a disabled digit keeps digit_n=4'hF for its slot, and the scan timing is unchanged.
REQ-020 segments SHALL be the hex decode of VALUE[4*idx+3:4*idx] (0=7'h40, 1=7'h79, 8=7'h00, F=7'h0E); in GAP, segments=7'h7F.
REQ-021 segments and digit_n SHALL be registered; a VALUE write becomes visible on segments one cycle after the store edge if that digit is currently lit.
REQ-022 A store simultaneous with a digit switch SHALL take effect; the new digit displays the new VALUE.
REQ-023 Back-to-back stores on consecutive cycles SHALL each be accepted; the last one wins.

Reset
REQ-024 While reset=1 at a clock edge: VALUE=16'h0000, CTRL=5'h0F, idx=0, counter=0, state=SHOW, segments=7'h7F, digit_n=4'hF.
REQ-025 Reset asserted mid-scan or mid-GAP SHALL abort to the reset state on that edge; stores during reset are ignored.
REQ-026 The first lit output after reset release SHALL appear on the next edge: digit 0 showing "0" (segments=7'h40, digit_n=4'hE).

Configuration
REQ-027 Macro SEG_BLINK_EN: when defined, a free-running 24-bit counter SHALL run; while CTRL[4]=1 and counter bit 23=1, digit_n is forced to 4'hF and the FSM continues scanning.
REQ-028 Without SEG_BLINK_EN, CTRL[4] SHALL be stored and read back but have no effect on outputs, and the blink counter SHALL not exist.

Verification
REQ-029 REFRESH_DIV=4; reset, store VALUE=32'h0000_1234 -> digit_n sequence E,F(gap),D,F,B,F,7,F,E with segments 4,3,2,1 (7'h19,7'h30,7'h24,7'h79), each digit lit exactly 4 cycles.
REQ-030 Store CTRL=5'h05 -> digits 1 and 3 show digit_n=4'hF in their slots; rd_data at BASE_ADDR+4 = 32'h5.
REQ-031 Store to BASE_ADDR+8 with data 32'hFFFF_FFFF -> hit=0, rd_data=0, VALUE and CTRL unchanged.
REQ-032 Store to VALUE on the same edge the FSM leaves GAP -> the new digit shows the new nibble on the first lit cycle.
REQ-033 Assert reset for one cycle while digit 2 is lit -> next cycle segments=7'h7F, digit_n=4'hF; the following cycle digit_n=4'hE, segments=7'h40.
REQ-034 With SEG_BLINK_EN and CTRL=5'h1F -> digit_n=4'hF whenever blink counter bit 23=1; without the macro, digit_n never stays at 4'hF beyond a single GAP cycle.

Source files
------------

// File: rtl/mmio_seg_display.sv
// Memory-mapped 4-digit hex 7-segment scanner: VALUE at BASE_ADDR, CTRL at BASE_ADDR+4.
// Optional blink gating is compiled in with the SEG_BLINK_EN macro.
module mmio_seg_display #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] data_adr,
  input  logic [31:0] write_data,
  output logic [31:0] rd_data,
  output logic        hit,
  output logic [6:0]  segments,
  output logic [3:0]  digit_n
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic {SHOW, GAP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   value_q, value_d;
  logic [4:0]    ctrl_q, ctrl_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    dig_q, dig_d;
  logic          sel_value, sel_ctrl, blank;
  logic [3:0]    nibble;
  logic          unused_wdata;

  assign unused_wdata = ^write_data[31:16];

  assign sel_value = (data_adr == BASE_ADDR);
  assign sel_ctrl  = (data_adr == BASE_ADDR + 32'd4);
  assign hit       = sel_value | sel_ctrl;

  always_comb begin
    rd_data = '0;
    if (sel_value)     rd_data = {16'b0, value_q};
    else if (sel_ctrl) rd_data = {27'b0, ctrl_q};
  end

`ifdef SEG_BLINK_EN
  logic [23:0] blink_q;
  always_ff @(posedge clk) begin
    if (reset) blink_q <= '0;
    else       blink_q <= blink_q + 24'd1;
  end
  assign blank = ctrl_q[4] & blink_q[23];
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    ctrl_d  = ctrl_q;
    if (mem_write && sel_value) value_d = write_data[15:0];
    if (mem_write && sel_ctrl)  ctrl_d  = write_data[4:0];
    case (state_q)
      SHOW: begin
        if (cnt_q == CNT_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = SHOW;
        idx_d   = idx_q + 2'd1;
      end
    endcase
  end

  // Outputs are a registered image of the current scan state, so a store lands
  // on the display one edge after it is accepted, including across a digit switch.
  assign nibble = value_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    seg_d = 7'h7F;
    dig_d = 4'hF;
    if (state_q == SHOW) begin
      case (nibble)
        4'h0: seg_d = 7'h40;
        4'h1: seg_d = 7'h79;
        4'h2: seg_d = 7'h24;
        4'h3: seg_d = 7'h30;
        4'h4: seg_d = 7'h19;
        4'h5: seg_d = 7'h12;
        4'h6: seg_d = 7'h02;
        4'h7: seg_d = 7'h78;
        4'h8: seg_d = 7'h00;
        4'h9: seg_d = 7'h10;
        4'hA: seg_d = 7'h08;
        4'hB: seg_d = 7'h03;
        4'hC: seg_d = 7'h46;
        4'hD: seg_d = 7'h21;
        4'hE: seg_d = 7'h06;
        default: seg_d = 7'h0E;
      endcase
      if (ctrl_q[idx_q] && !blank) dig_d = ~(4'b0001 << idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SHOW;
      idx_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      ctrl_q  <= 5'h0F;
      seg_q   <= 7'h7F;
      dig_q   <= 4'hF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      ctrl_q  <= ctrl_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign segments = seg_q;
  assign digit_n  = dig_q;

endmodule

// File: tb/tb_mmio_seg_display.sv
// Randomized self-checking bench for mmio_seg_display (default build, SEG_BLINK_EN undefined).
module tb_mmio_seg_display;

  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam int D = 4;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        reset, mem_write;
  logic [31:0] data_adr, write_data, rd_data;
  logic        hit;
  logic [6:0]  segments;
  logic [3:0]  digit_n;

  mmio_seg_display #(.BASE_ADDR(BASE), .REFRESH_DIV(D)) dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr),
    .write_data(write_data), .rd_data(rd_data), .hit(hit),
    .segments(segments), .digit_n(digit_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: time since reset, plus architectural VALUE/CTRL.
  int          t;
  logic [15:0] mv;
  logic [4:0]  mc;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_dig;
  logic [31:0] exp_rd, act_rd;
  logic        exp_hit, act_hit;

  task automatic tick(input logic rst, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    int pos, slot;
    logic [3:0] nib;
    reset = rst; mem_write = we; data_adr = adr; write_data = dat;
    #1;
    act_hit = hit; act_rd = rd_data;
    exp_hit = (adr == BASE) || (adr == BASE + 32'd4);
    exp_rd  = (adr == BASE) ? {16'b0, mv} : (adr == BASE + 32'd4) ? {27'b0, mc} : 32'd0;
    exp_seg = 7'h7F; exp_dig = 4'hF;
    if (!rst) begin
      pos  = t % (D + 1);
      slot = (t / (D + 1)) % 4;
      if (pos != D) begin
        nib = 4'((mv >> (4 * slot)) & 16'hF);
        exp_seg = HEX[nib];
        if (mc[slot]) exp_dig = ~(4'b0001 << slot);
      end
    end
    @(posedge clk); #1;
    if (rst) begin
      t = 0; mv = 16'h0000; mc = 5'h0F;
    end else begin
      t++;
      if (we && adr == BASE) mv = dat[15:0];
      if (we && adr == BASE + 32'd4) mc = dat[4:0];
    end
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, BASE, 32'hFFFF_FFFF);
    tick(1'b1, 1'b0, BASE, 32'h0);
    n_cmp++;
    if (segments !== 7'h7F || digit_n !== 4'hF) begin
      n_err++; $display("FAIL reset_out seg=%h dig=%h required seg=7f dig=f", segments, digit_n);
    end
    n_cmp++;
    if (act_rd !== 32'd0) begin
      n_err++; $display("FAIL reset_value rd=%h required 0", act_rd);
    end
    tick(1'b0, 1'b0, BASE + 32'd4, 32'h0);
    n_cmp++;
    if (segments !== 7'h40 || digit_n !== 4'hE || act_rd !== 32'h0F) begin
      n_err++; $display("FAIL reset_first_lit seg=%h dig=%h rd=%h required 40 e f", segments, digit_n, act_rd);
    end
  endtask

  task automatic test_scan();
    tick(1'b1, 1'b0, 32'h0, 32'h0);
    tick(1'b0, 1'b1, BASE, 32'h0000_1234);
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'b0, BASE, 32'h0);
      n_cmp++;
      if (segments !== exp_seg || digit_n !== exp_dig || act_rd !== exp_rd || act_hit !== exp_hit) begin
        n_err++;
        $display("FAIL scan t=%0d seg=%h dig=%h rd=%h hit=%b required seg=%h dig=%h rd=%h hit=%b",
                 t, segments, digit_n, act_rd, act_hit, exp_seg, exp_dig, exp_rd, exp_hit);
      end
    end
  endtask

  task automatic test_ctrl_mask();
    tick(1'b0, 1'b1, BASE + 32'd4, 32'h0000_0005);
    for (int i = 0; i < 25; i++) begin
      tick(1'b0, 1'b0, BASE + 32'd4, 32'h0);
      n_cmp++;
      if (segments !== exp_seg || digit_n !== exp_dig || act_rd !== 32'h5) begin
        n_err++;
        $display("FAIL ctrl_mask t=%0d seg=%h dig=%h rd=%h required seg=%h dig=%h rd=5",
                 t, segments, digit_n, act_rd, exp_seg, exp_dig);
      end
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] adr;
    for (int i = 0; i < 6; i++) begin
      adr = (i == 0) ? BASE + 32'd8 : $urandom;
      if (adr == BASE || adr == BASE + 32'd4) adr = BASE + 32'd12;
      tick(1'b0, 1'b1, adr, 32'hFFFF_FFFF);
      n_cmp++;
      if (act_hit !== 1'b0 || act_rd !== 32'd0 || segments !== exp_seg || digit_n !== exp_dig) begin
        n_err++;
        $display("FAIL unmapped adr=%h hit=%b rd=%h seg=%h dig=%h required hit=0 rd=0 seg=%h dig=%h",
                 adr, act_hit, act_rd, segments, digit_n, exp_seg, exp_dig);
      end
    end
    tick(1'b0, 1'b0, BASE, 32'h0);
    n_cmp++;
    if (act_rd !== {16'b0, mv}) begin
      n_err++; $display("FAIL unmapped_value rd=%h required %h", act_rd, {16'b0, mv});
    end
  endtask

  task automatic test_gap_store();
    logic [15:0] v;
    int slot;
    tick(1'b0, 1'b1, BASE + 32'd4, 32'h0000_000F);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 2 * (D + 1) && (t % (D + 1)) != D; g++) tick(1'b0, 1'b0, 32'h0, 32'h0);
      v = 16'($urandom);
      slot = ((t + 1) / (D + 1)) % 4;
      tick(1'b0, 1'b1, BASE, {16'hABCD, v});
      tick(1'b0, 1'b0, 32'h0, 32'h0);
      n_cmp++;
      if (segments !== HEX[4'((v >> (4 * slot)) & 16'hF)] || digit_n !== ~(4'b0001 << slot)) begin
        n_err++;
        $display("FAIL gap_store slot=%0d seg=%h dig=%h required seg=%h dig=%h",
                 slot, segments, digit_n, HEX[4'((v >> (4 * slot)) & 16'hF)], ~(4'b0001 << slot));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] last;
    for (int i = 0; i < 5; i++) begin
      last = $urandom;
      tick(1'b0, 1'b1, BASE, last);
    end
    tick(1'b0, 1'b0, BASE, 32'h0);
    n_cmp++;
    if (act_rd !== {16'b0, last[15:0]} || segments !== exp_seg || digit_n !== exp_dig) begin
      n_err++; $display("FAIL back_to_back rd=%h required %h", act_rd, {16'b0, last[15:0]});
    end
  endtask

  task automatic test_reset_mid();
    for (int g = 0; g < 4 * (D + 1) && !((t / (D + 1)) % 4 == 2 && (t % (D + 1)) == 1); g++)
      tick(1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (digit_n !== 4'hB) begin
      n_err++; $display("FAIL reset_mid_pre dig=%h required b", digit_n);
    end
    tick(1'b1, 1'b1, BASE, 32'h0000_FFFF);
    n_cmp++;
    if (segments !== 7'h7F || digit_n !== 4'hF) begin
      n_err++; $display("FAIL reset_mid seg=%h dig=%h required seg=7f dig=f", segments, digit_n);
    end
    tick(1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (segments !== 7'h40 || digit_n !== 4'hE) begin
      n_err++; $display("FAIL reset_mid_after seg=%h dig=%h required seg=40 dig=e", segments, digit_n);
    end
  endtask

  task automatic test_random();
    logic [31:0] adr;
    logic rst;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: adr = BASE;
        1: adr = BASE + 32'd4;
        2: adr = BASE + 32'd8;
        default: adr = $urandom;
      endcase
      rst = ($urandom_range(0, 79) == 0);
      tick(rst, 1'($urandom_range(0, 1)), adr, $urandom);
      n_cmp++;
      if (segments !== exp_seg || digit_n !== exp_dig || act_rd !== exp_rd || act_hit !== exp_hit) begin
        n_err++;
        $display("FAIL random i=%0d seg=%h dig=%h rd=%h hit=%b required seg=%h dig=%h rd=%h hit=%b",
                 i, segments, digit_n, act_rd, act_hit, exp_seg, exp_dig, exp_rd, exp_hit);
      end
    end
  endtask

  task automatic test_blink_disabled();
    int run = 0;
    tick(1'b0, 1'b1, BASE + 32'd4, 32'h0000_001F);
    for (int i = 0; i < 200; i++) begin
      tick(1'b0, 1'b0, 32'h0, 32'h0);
      run = (digit_n === 4'hF) ? run + 1 : 0;
      n_cmp++;
      if (run > 1) begin
        n_err++; $display("FAIL blink_disabled cycle=%0d dark_run=%0d required at most 1", i, run);
      end
    end
  endtask

  initial begin
    reset = 1'b1; mem_write = 1'b0; data_adr = '0; write_data = '0;
    t = 0; mv = '0; mc = 5'h0F;
    test_reset();
    test_scan();
    test_ctrl_mask();
    test_unmapped();
    test_gap_store();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_blink_disabled();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
